// File: rtl/hoene_link_supervisor.sv
// Link supervisor for the Manchester receive chain: settles, acquires sync, watches the
// error rate while locked and toggles the line input on timeout, sync loss or too many errors.
module hoene_link_supervisor #(
    parameter int ACQ_TIMEOUT = 4096,
    parameter int HOLDOFF     = 256,
    parameter int ERR_WINDOW  = 64,
    parameter int ERR_LIMIT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_sync,
    input  logic       in_clk,
    input  logic       in_error,
    input  logic       test_mode,
    input  logic       force_sel,
    output logic       sel,
    output logic       link_up,
    output logic [3:0] switch_count,
    output logic [1:0] state
);

    localparam logic [1:0] SETTLE  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] SWITCH  = 2'd3;

    // One cycle counter serves both SETTLE and ACQUIRE, so it is sized for the longer of the two.
    localparam int CYC_MAX = (ACQ_TIMEOUT > HOLDOFF) ? ACQ_TIMEOUT : HOLDOFF;
    localparam int CYC_W   = $clog2(CYC_MAX) + 1;
    localparam int BIT_W   = $clog2(ERR_WINDOW) + 1;
    localparam int ERR_W   = $clog2(ERR_LIMIT) + 1;

    localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(HOLDOFF - 1);
    localparam logic [CYC_W-1:0] ACQ_LAST  = CYC_W'(ACQ_TIMEOUT - 1);
    localparam logic [BIT_W-1:0] WIN_FULL  = BIT_W'(ERR_WINDOW);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(ERR_LIMIT);

    logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt, bit_inc;
    logic [ERR_W-1:0] err_cnt, err_nxt, err_inc;
    logic [1:0]       state_nxt;
    logic             clk_prev, err_prev;
    logic             clk_rise, err_rise;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        clk_rise  = in_clk & ~clk_prev;
        err_rise  = in_error & ~err_prev;
        bit_inc   = bit_cnt + {{(BIT_W-1){1'b0}}, clk_rise};
        err_inc   = (err_rise && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        err_nxt   = err_cnt;

        if (test_mode) begin
            state_nxt = SETTLE;
            cyc_nxt   = '0;
            bit_nxt   = '0;
            err_nxt   = '0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cyc_cnt == HOLD_LAST) begin
                        state_nxt = ACQUIRE;
                        cyc_nxt   = '0;
                    end else begin
                        cyc_nxt = cyc_cnt + 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (in_sync) begin
                        state_nxt = LOCKED;
                        cyc_nxt   = '0;
                        bit_nxt   = '0;
                        err_nxt   = '0;
                    end else if (cyc_cnt == ACQ_LAST) begin
                        state_nxt = SWITCH;
                        cyc_nxt   = '0;
                    end else begin
                        cyc_nxt = cyc_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    // The error in this cycle is counted before the window-close test.
                    if (!in_sync || err_inc == ERR_MAX) begin
                        state_nxt = SWITCH;
                        bit_nxt   = '0;
                        err_nxt   = '0;
                    end else if (bit_inc == WIN_FULL) begin
                        bit_nxt = '0;
                        err_nxt = '0;
                    end else begin
                        bit_nxt = bit_inc;
                        err_nxt = err_inc;
                    end
                end
                default: begin
                    state_nxt = SETTLE;
                    cyc_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SETTLE;
            sel          <= 1'b0;
            link_up      <= 1'b0;
            switch_count <= '0;
            cyc_cnt      <= '0;
            bit_cnt      <= '0;
            err_cnt      <= '0;
            clk_prev     <= 1'b0;
            err_prev     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            cyc_cnt  <= cyc_nxt;
            bit_cnt  <= bit_nxt;
            err_cnt  <= err_nxt;
            clk_prev <= in_clk;
            err_prev <= in_error;
            link_up  <= (state_nxt == LOCKED);
            if (test_mode) begin
                sel <= force_sel;
            end else if (state_nxt == SWITCH) begin
                sel <= ~sel;
                if (switch_count != 4'd15) begin
                    switch_count <= switch_count + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hoene_link_supervisor.sv
// Self-checking bench for hoene_link_supervisor: directed scenarios followed by random
// stimulus, each cycle compared with a phase/age reference model.
module tb_hoene_link_supervisor;

    localparam int ACQ_TIMEOUT = 16;
    localparam int HOLDOFF     = 4;
    localparam int ERR_WINDOW  = 8;
    localparam int ERR_LIMIT   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_sync = 1'b0, in_clk = 1'b0, in_error = 1'b0;
    logic       test_mode = 1'b0, force_sel = 1'b0;
    logic       sel, link_up;
    logic [3:0] switch_count;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // Reference model: phase number as defined by the state output, plus elapsed cycles.
    int m_phase, m_age, m_bits, m_errs, m_sw;
    bit m_sel, m_link, m_pclk, m_perr;

    hoene_link_supervisor #(
        .ACQ_TIMEOUT(ACQ_TIMEOUT), .HOLDOFF(HOLDOFF),
        .ERR_WINDOW(ERR_WINDOW), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_sync(in_sync), .in_clk(in_clk),
        .in_error(in_error), .test_mode(test_mode), .force_sel(force_sel),
        .sel(sel), .link_up(link_up), .switch_count(switch_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, int'(state), m_phase);
        check({tag, ".sel"}, int'(sel), int'(m_sel));
        check({tag, ".link_up"}, int'(link_up), int'(m_link));
        check({tag, ".switch_count"}, int'(switch_count), m_sw);
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_bits = 0; m_errs = 0; m_sw = 0;
        m_sel = 1'b0; m_link = 1'b0; m_pclk = 1'b0; m_perr = 1'b0;
    endtask

    task automatic model_switch();
        m_phase = 3;
        m_sel   = ~m_sel;
        m_link  = 1'b0;
        m_sw    = (m_sw < 15) ? m_sw + 1 : 15;
    endtask

    task automatic model_step(input bit s, input bit c, input bit e, input bit tm, input bit fs);
        bit rc, re;
        rc = c && !m_pclk;
        re = e && !m_perr;
        m_pclk = c;
        m_perr = e;
        if (tm) begin
            m_sel = fs; m_phase = 0; m_age = 0; m_link = 1'b0;
            return;
        end
        case (m_phase)
            0: begin
                m_age++;
                if (m_age == HOLDOFF) begin m_phase = 1; m_age = 0; end
            end
            1: begin
                m_age++;
                if (s) begin
                    m_phase = 2; m_link = 1'b1; m_bits = 0; m_errs = 0;
                end else if (m_age == ACQ_TIMEOUT) begin
                    model_switch();
                end
            end
            2: begin
                m_bits += int'(rc);
                m_errs += int'(re);
                if (!s || m_errs >= ERR_LIMIT) model_switch();
                else if (m_bits == ERR_WINDOW) begin m_bits = 0; m_errs = 0; end
            end
            default: begin m_phase = 0; m_age = 0; end
        endcase
    endtask

    // Drive one cycle of inputs, clock it, update the model, compare away from the edge.
    task automatic cycle(input bit s, input bit c, input bit e, input bit tm, input bit fs);
        in_sync = s; in_clk = c; in_error = e; test_mode = tm; force_sel = fs;
        @(posedge clk);
        model_step(s, c, e, tm, fs);
        #1;
        check_all("cyc");
    endtask

    task automatic bit_pulse(input bit s, input bit e);
        cycle(s, 1'b1, e, 1'b0, 1'b0);
        cycle(s, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        in_sync = 0; in_clk = 0; in_error = 0; test_mode = 0; force_sel = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int sw_saved;
        #2;

        // 1: acquisition timeout with no sync
        do_reset();
        check("s1.reset_state", int'(state), 0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s1.switch_state", int'(state), 3);
        check("s1.switch_sel", int'(sel), 1);
        check("s1.switch_cnt", int'(switch_count), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s1.back_settle", int'(state), 0);

        // 2: sync in third ACQUIRE cycle
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s2.locked", int'(state), 2);
        check("s2.link_up", int'(link_up), 1);
        check("s2.sel", int'(sel), 0);

        // 3: three windows with one error each stay locked
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < ERR_WINDOW; b++) bit_pulse(1'b1, b == 3);
        check("s3.locked", int'(state), 2);
        check("s3.no_switch", int'(switch_count), 0);

        // 4: two errors within five bits force a switch
        bit_pulse(1'b1, 1'b1);
        bit_pulse(1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("s4.switch_state", int'(state), 3);
        check("s4.sel", int'(sel), 1);
        check("s4.link_down", int'(link_up), 0);
        check("s4.switch_cnt", int'(switch_count), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: repeated timeouts saturate the switch counter
        for (int i = 0; i < 20 * (HOLDOFF + ACQ_TIMEOUT + 1); i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s5.saturated", int'(switch_count), 15);

        // 6: test mode while locked, then async reset while locked
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s6.locked", int'(state), 2);
        sw_saved = int'(switch_count);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("s6.tm_sel", int'(sel), 1);
        check("s6.tm_state", int'(state), 0);
        check("s6.tm_link", int'(link_up), 0);
        check("s6.tm_count", int'(switch_count), sw_saved);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s6.still_settle", int'(state), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s6.acquire", int'(state), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s6.relocked", int'(state), 2);
        #3;
        do_reset();
        check("s6.rst_sel", int'(sel), 0);

        // 7: random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bit s, c, e, tm, fs;
            s  = ($urandom_range(0, 99) < 97);
            c  = 1'($urandom_range(0, 1));
            e  = ($urandom_range(0, 99) < 4);
            tm = ($urandom_range(0, 199) < 2);
            fs = 1'($urandom_range(0, 1));
            cycle(s, c, e, tm, fs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
